// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm-clock family of blocks.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam int DEF_TONE_DIV      = 4;
  localparam int DEF_BEEP_LEN      = 8;
  localparam int DEF_SNOOZE_CYCLES = 32;
  localparam int DEF_TIMEOUT_BEEPS = 16;
  localparam int DEF_MAX_SNOOZE    = 3;
  localparam int SNOOZE_CNT_W      = 2;

  // Counter width for a bound, never narrower than one bit.
  function automatic int cnt_width(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Square-wave tone source: toggles every TONE_DIV cycles, restarts high on clear.
module alarm_tone_gen
  import alarm_pkg::*;
#(
  parameter int TONE_DIV = DEF_TONE_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tone
);

  localparam int CNT_W = cnt_width(TONE_DIV);

  logic [CNT_W-1:0] tone_cnt_reg;
  logic             tone_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tone_cnt_reg <= '0;
      tone_reg     <= 1'b0;
    end else if (clear) begin
      tone_cnt_reg <= '0;
      tone_reg     <= 1'b1;
    end else if (tone_cnt_reg == CNT_W'(TONE_DIV - 1)) begin
      tone_cnt_reg <= '0;
      tone_reg     <= ~tone_reg;
    end else begin
      tone_cnt_reg <= tone_cnt_reg + CNT_W'(1);
    end
  end

  assign tone = tone_reg;

endmodule

// File: rtl/alarm_buzzer_ctrl.sv
// Alarm buzzer controller: turns an alarm match edge into a gated beep with
// snooze, dismiss and auto-timeout.
module alarm_buzzer_ctrl
  import alarm_pkg::*;
#(
  parameter int TONE_DIV      = DEF_TONE_DIV,
  parameter int BEEP_LEN      = DEF_BEEP_LEN,
  parameter int SNOOZE_CYCLES = DEF_SNOOZE_CYCLES,
  parameter int TIMEOUT_BEEPS = DEF_TIMEOUT_BEEPS,
  parameter int MAX_SNOOZE    = DEF_MAX_SNOOZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alarm_in,
  input  logic                    snooze,
  input  logic                    dismiss,
  output logic                    buzzer,
  output logic                    ringing,
  output logic                    snoozed,
  output logic [SNOOZE_CNT_W-1:0] snooze_count
);

  localparam int BEEP_W   = cnt_width(2 * BEEP_LEN);
  localparam int PERIOD_W = cnt_width(TIMEOUT_BEEPS + 1);
  localparam int TIMER_W  = cnt_width(SNOOZE_CYCLES);

  state_t                  state_reg;
  logic                    alarm_d_reg;
  logic                    armed_reg;
  logic [BEEP_W-1:0]       beep_cnt_reg;
  logic [PERIOD_W-1:0]     period_cnt_reg;
  logic [TIMER_W-1:0]      snooze_timer_reg;
  logic [SNOOZE_CNT_W-1:0] snooze_count_reg;

  logic rise;
  logic beep_wrap;
  logic timeout_hit;
  logic can_snooze;
  logic tone;

  // armed_reg blocks a level that was already high across reset from
  // looking like a fresh edge; alarm_in must be seen low first.
  always_comb begin
    rise        = alarm_in & ~alarm_d_reg & armed_reg;
    beep_wrap   = (beep_cnt_reg == BEEP_W'(2 * BEEP_LEN - 1));
    timeout_hit = beep_wrap && (period_cnt_reg == PERIOD_W'(TIMEOUT_BEEPS - 1));
    can_snooze  = (snooze_count_reg < SNOOZE_CNT_W'(MAX_SNOOZE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      alarm_d_reg      <= 1'b0;
      armed_reg        <= 1'b0;
      beep_cnt_reg     <= '0;
      period_cnt_reg   <= '0;
      snooze_timer_reg <= '0;
      snooze_count_reg <= '0;
    end else begin
      alarm_d_reg <= alarm_in;
      if (!alarm_in) armed_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (rise) begin
            state_reg      <= RING;
            beep_cnt_reg   <= '0;
            period_cnt_reg <= '0;
          end
        end
        RING: begin
          if (dismiss) begin
            state_reg        <= IDLE;
            snooze_count_reg <= '0;
          end else if (snooze && can_snooze) begin
            state_reg        <= SNOOZE;
            snooze_count_reg <= snooze_count_reg + SNOOZE_CNT_W'(1);
            snooze_timer_reg <= TIMER_W'(SNOOZE_CYCLES - 1);
          end else if (timeout_hit) begin
            state_reg        <= IDLE;
            snooze_count_reg <= '0;
          end else if (beep_wrap) begin
            beep_cnt_reg   <= '0;
            period_cnt_reg <= period_cnt_reg + PERIOD_W'(1);
          end else begin
            beep_cnt_reg <= beep_cnt_reg + BEEP_W'(1);
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            state_reg        <= IDLE;
            snooze_count_reg <= '0;
          end else if (snooze_timer_reg == '0) begin
            state_reg      <= RING;
            beep_cnt_reg   <= '0;
            period_cnt_reg <= '0;
          end else begin
            snooze_timer_reg <= snooze_timer_reg - TIMER_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Holding the tone generator in clear outside RING makes every RING entry
  // start on a fresh high half-period.
  alarm_tone_gen #(
    .TONE_DIV(TONE_DIV)
  ) u_tone (
    .clk  (clk),
    .rst  (rst),
    .clear(state_reg != RING),
    .tone (tone)
  );

  assign ringing      = (state_reg == RING);
  assign snoozed      = (state_reg == SNOOZE);
  assign buzzer       = ringing & tone & (beep_cnt_reg < BEEP_W'(BEEP_LEN));
  assign snooze_count = snooze_count_reg;

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Directed scoreboard bench for alarm_buzzer_ctrl with default parameters.
module tb_alarm_buzzer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       alarm_in;
  logic       snooze;
  logic       dismiss;
  logic       buzzer;
  logic       ringing;
  logic       snoozed;
  logic [1:0] snooze_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic       ringing;
    logic       buzzer;
    logic       snoozed;
    logic [1:0] count;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alarm_buzzer_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .alarm_in    (alarm_in),
    .snooze      (snooze),
    .dismiss     (dismiss),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozed     (snoozed),
    .snooze_count(snooze_count)
  );

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic push(input string tag, input logic r, input logic b,
                      input logic s, input logic [1:0] c);
    exp_t e;
    e.tag = tag; e.ringing = r; e.buzzer = b; e.snoozed = s; e.count = c;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty got=0 entries exp=1");
      return;
    end
    e = sb.pop_front();
    $display("txn %s: ring=%0b buz=%0b snz=%0b cnt=%0d", e.tag, ringing, buzzer, snoozed, snooze_count);
    checks++;
    assert (ringing === e.ringing) else begin
      failures++;
      $error("FAIL %s ringing got=%0b exp=%0b", e.tag, ringing, e.ringing);
    end
    checks++;
    assert (buzzer === e.buzzer) else begin
      failures++;
      $error("FAIL %s buzzer got=%0b exp=%0b", e.tag, buzzer, e.buzzer);
    end
    checks++;
    assert (snoozed === e.snoozed) else begin
      failures++;
      $error("FAIL %s snoozed got=%0b exp=%0b", e.tag, snoozed, e.snoozed);
    end
    checks++;
    assert (snooze_count === e.count) else begin
      failures++;
      $error("FAIL %s snooze_count got=%0d exp=%0d", e.tag, snooze_count, e.count);
    end
  endtask

  task automatic do_rise();
    alarm_in = 1'b0;
    step(1);
    alarm_in = 1'b1;
    step(1);
  endtask

  task automatic pulse(input logic s, input logic d);
    snooze  = s;
    dismiss = d;
    step(1);
    snooze  = 1'b0;
    dismiss = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alarm_in = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    @(negedge clk);
    step(2);
    rst = 1'b0;
    push("reset", 0, 0, 0, 2'd0);
    check_out();

    // Ring pattern: four tone-high cycles at the start of each 16-cycle beep.
    step(8);
    alarm_in = 1'b1;
    step(1);
    for (int off = 0; off < 32; off++) begin
      push("ring_pattern", 1, ((off % 16) < 4), 0, 2'd0);
      check_out();
      step(1);
    end
    step(223);
    push("pre_timeout", 1, 0, 0, 2'd0);
    check_out();
    step(1);
    push("timeout", 0, 0, 0, 2'd0);
    check_out();
    step(6);
    push("no_retrigger", 0, 0, 0, 2'd0);
    check_out();

    // Snooze 1
    do_rise();
    push("ring2_entry", 1, 1, 0, 2'd0);
    check_out();
    step(2);
    pulse(1, 0);
    push("snooze1", 0, 0, 1, 2'd1);
    check_out();
    step(31);
    push("snooze1_last", 0, 0, 1, 2'd1);
    check_out();
    step(1);
    push("resume1", 1, 1, 0, 2'd1);
    check_out();

    // Snooze 2, with a rising alarm_in that must be ignored
    pulse(1, 0);
    push("snooze2", 0, 0, 1, 2'd2);
    check_out();
    alarm_in = 1'b0;
    step(1);
    alarm_in = 1'b1;
    step(1);
    push("snooze_rise_ignored", 0, 0, 1, 2'd2);
    check_out();
    step(29);
    push("snooze2_last", 0, 0, 1, 2'd2);
    check_out();
    step(1);
    push("resume2", 1, 1, 0, 2'd2);
    check_out();

    // Snooze 3, then a fourth pulse that is refused
    pulse(1, 0);
    push("snooze3", 0, 0, 1, 2'd3);
    check_out();
    step(31);
    step(1);
    push("resume3", 1, 1, 0, 2'd3);
    check_out();
    pulse(1, 0);
    push("snooze4_refused", 1, 1, 0, 2'd3);
    check_out();
    pulse(0, 1);
    push("dismiss_ring", 0, 0, 0, 2'd0);
    check_out();

    // Dismiss from SNOOZE
    do_rise();
    push("ring3_entry", 1, 1, 0, 2'd0);
    check_out();
    pulse(1, 0);
    push("snooze_a", 0, 0, 1, 2'd1);
    check_out();
    pulse(0, 1);
    push("dismiss_snooze", 0, 0, 0, 2'd0);
    check_out();

    // Snooze and dismiss together: dismiss wins
    do_rise();
    push("ring4_entry", 1, 1, 0, 2'd0);
    check_out();
    pulse(1, 1);
    push("snooze_dismiss", 0, 0, 0, 2'd0);
    check_out();

    // Pulses in IDLE do nothing
    pulse(1, 0);
    push("idle_snooze", 0, 0, 0, 2'd0);
    check_out();
    pulse(0, 1);
    push("idle_dismiss", 0, 0, 0, 2'd0);
    check_out();

    // Reset mid-RING with alarm_in held high
    do_rise();
    push("ring5_entry", 1, 1, 0, 2'd0);
    check_out();
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    push("reset_mid_ring", 0, 0, 0, 2'd0);
    check_out();
    step(4);
    push("held_high_after_reset", 0, 0, 0, 2'd0);
    check_out();
    do_rise();
    push("ring_after_new_edge", 1, 1, 0, 2'd0);
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
